// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle RV32I controller.
// The mem_ready handshake is present only when MEM_WAIT_EN is defined.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 3,
    parameter int STATE_W    = 4
);
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic                  Zero_Flag;
    logic                  Sign_Flag;
`ifdef MEM_WAIT_EN
    logic                  mem_ready;
`endif
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [1:0]            ImmSrc;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  IllegalOp;
    logic [STATE_W-1:0]    State;

    modport master (
`ifdef MEM_WAIT_EN
        input  mem_ready,
`endif
        input  opcode, func3, func7, Zero_Flag, Sign_Flag,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
    );

    modport slave (
`ifdef MEM_WAIT_EN
        output mem_ready,
`endif
        output opcode, func3, func7, Zero_Flag, Sign_Flag,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the shared-ALU, shared-memory multicycle RV32I datapath.
// Optional feature: define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int STATE_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.master  bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9),
        JAL      = STATE_W'(10)
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     state_r;
    state_t     next_state_s;
    logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s, illegal_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, imm_src_s;
    logic [2:0] alu_ctrl_s;
    logic       mem_go_s;
    logic       unused_func7_s;

    function automatic logic [2:0] alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7b5);
        logic [2:0] ctrl;
        case (f3)
            3'b000:  ctrl = (op == OP_RTYPE && f7b5) ? 3'b001 : 3'b000;
            3'b010:  ctrl = 3'b101;
            3'b110:  ctrl = 3'b011;
            3'b111:  ctrl = 3'b010;
            default: ctrl = 3'b000;
        endcase
        return ctrl;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic sign);
        logic taken;
        case (f3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = sign;
            3'b101:  taken = ~sign;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

`ifdef MEM_WAIT_EN
    assign mem_go_s = bus.mem_ready;
`else
    assign mem_go_s = 1'b1;
`endif

    assign unused_func7_s = ^{bus.func7[6], bus.func7[4:0]};

    // State register; async reset parks the FSM in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Moore output decode; everything not named for a state stays 0.
    always_comb begin
        next_state_s = FETCH;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        imm_src_s    = 2'b00;
        alu_ctrl_s   = 3'b000;
        case (state_r)
            FETCH: begin
                ir_write_s   = mem_go_s;
                pc_write_s   = mem_go_s;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                next_state_s = mem_go_s ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                imm_src_s   = 2'b10;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: next_state_s = MEMADR;
                    OP_RTYPE:          next_state_s = EXECUTER;
                    OP_ITYPE:          next_state_s = EXECUTEI;
                    OP_BR:             next_state_s = BRANCH;
                    OP_JAL:            next_state_s = JAL;
                    default: begin
                        next_state_s = FETCH;
                        illegal_s    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (bus.opcode == OP_LOAD) begin
                    imm_src_s    = 2'b00;
                    next_state_s = MEMREAD;
                end else begin
                    imm_src_s    = 2'b01;
                    next_state_s = MEMWRITE;
                end
            end
            MEMREAD: begin
                adr_src_s    = 1'b1;
                next_state_s = mem_go_s ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                next_state_s = mem_go_s ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                alu_src_a_s  = 2'b10;
                alu_ctrl_s   = alu_decode(bus.opcode, bus.func3, bus.func7[5]);
                next_state_s = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                alu_ctrl_s   = alu_decode(bus.opcode, bus.func3, bus.func7[5]);
                next_state_s = ALUWB;
            end
            ALUWB: begin
                reg_write_s  = 1'b1;
                next_state_s = FETCH;
            end
            BRANCH: begin
                alu_src_a_s  = 2'b10;
                alu_ctrl_s   = 3'b001;
                pc_write_s   = branch_taken(bus.func3, bus.Zero_Flag, bus.Sign_Flag);
                next_state_s = FETCH;
            end
            JAL: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                pc_write_s   = 1'b1;
                next_state_s = ALUWB;
            end
            default: next_state_s = FETCH;
        endcase
    end

    // Write strobes are gated by rst_n so an aborted instruction cannot commit.
    assign bus.PCWrite    = pc_write_s & rst_n;
    assign bus.IRWrite    = ir_write_s & rst_n;
    assign bus.RegWrite   = reg_write_s & rst_n;
    assign bus.MemWrite   = mem_write_s & rst_n;
    assign bus.IllegalOp  = illegal_s & rst_n;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ImmSrc     = imm_src_s;
    assign bus.ALUControl = ALU_CTRL_W'(alu_ctrl_s);
    assign bus.State      = state_r;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed plan items plus
// randomized instructions compared against an instruction-level reference model.
module tb_multicycle_control_unit;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    multicycle_control_unit_if #(.ALU_CTRL_W(3), .STATE_W(4)) bus ();

    multicycle_control_unit #(.ALU_CTRL_W(3), .STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: which state numbers an instruction visits, from its opcode.
    function automatic void expected_path(input logic [6:0] op, output int path[$],
                                          output bit illegal);
        illegal = 1'b0;
        case (op)
            7'b0000011: path = '{0, 1, 2, 3, 4};
            7'b0100011: path = '{0, 1, 2, 5};
            7'b0110011: path = '{0, 1, 6, 8};
            7'b0010011: path = '{0, 1, 7, 8};
            7'b1100011: path = '{0, 1, 9};
            7'b1101111: path = '{0, 1, 10, 8};
            default: begin
                path    = '{0, 1};
                illegal = 1'b1;
            end
        endcase
    endfunction

    function automatic int exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return (op == 7'b0110011 && f7[5]) ? 1 : 0;
            3'd2:    return 5;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_taken(input logic [2:0] f3, input logic z, input logic s);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return s;
            3'd5:    return !s;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one instruction starting from a FETCH negedge and checks every cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic s);
        int path[$];
        bit ill;
        int st;
        bus.opcode = op; bus.func3 = f3; bus.func7 = f7;
        bus.Zero_Flag = z; bus.Sign_Flag = s;
        expected_path(op, path, ill);
        foreach (path[i]) begin
            st = path[i];
            #1;
            check_val("state", 32'(bus.State), 32'(st));
            check_val("regwrite", 32'(bus.RegWrite), 32'(st == 4 || st == 8));
            check_val("memwrite", 32'(bus.MemWrite), 32'(st == 5));
            check_val("irwrite", 32'(bus.IRWrite), 32'(st == 0));
            check_val("pcwrite", 32'(bus.PCWrite),
                      32'(st == 0 || st == 10 || (st == 9 && exp_taken(f3, z, s))));
            check_val("illegal", 32'(bus.IllegalOp), 32'(st == 1 && ill));
            check_val("adrsrc", 32'(bus.AdrSrc), 32'(st == 3 || st == 5));
            check_val("resultsrc", 32'(bus.ResultSrc), (st == 0) ? 32'd2 : (st == 4) ? 32'd1 : 32'd0);
            check_val("alusrca", 32'(bus.ALUSrcA),
                      (st == 1 || st == 10) ? 32'd1 :
                      (st == 2 || st == 6 || st == 7 || st == 9) ? 32'd2 : 32'd0);
            check_val("alusrcb", 32'(bus.ALUSrcB),
                      (st == 0 || st == 10) ? 32'd2 : (st == 1 || st == 2 || st == 7) ? 32'd1 : 32'd0);
            check_val("immsrc", 32'(bus.ImmSrc),
                      (st == 1) ? 32'd2 : (st == 2 && op == 7'b0100011) ? 32'd1 : 32'd0);
            check_val("aluctrl", 32'(bus.ALUControl),
                      (st == 6 || st == 7) ? 32'(exp_alu(op, f3, f7)) : (st == 9) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);
            // Flags outside BRANCH must not matter; scramble them.
            bus.Zero_Flag = ($urandom_range(0, 1) == 1);
            bus.Sign_Flag = ($urandom_range(0, 1) == 1);
            if (i + 1 < path.size() && path[i + 1] == 9) begin
                bus.Zero_Flag = z;
                bus.Sign_Flag = s;
            end else begin
                bus.Zero_Flag = bus.Zero_Flag;
            end
        end
        #1;
        check_val("back_to_fetch", 32'(bus.State), 32'd0);
    endtask

    logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};

    initial begin
        rst_n = 1'b0;
        bus.opcode = 7'b0000011; bus.func3 = 3'b010; bus.func7 = 7'b0000000;
        bus.Zero_Flag = 1'b0; bus.Sign_Flag = 1'b0;
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_state", 32'(bus.State), 32'd0);
        check_val("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
        check_val("rst_irwrite", 32'(bus.IRWrite), 32'd0);
        check_val("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        check_val("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check_val("rst_alusrcb", 32'(bus.ALUSrcB), 32'd2);
        check_val("rst_resultsrc", 32'(bus.ResultSrc), 32'd2);
        rst_n = 1'b1;

        // Directed plan items.
        run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);  // lw
        run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);  // sub
        run_instr(7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0);  // bne taken
        run_instr(7'b1100011, 3'b101, 7'b0000000, 1'b0, 1'b1);  // bge not taken
        run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0);  // beq taken
        run_instr(7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0);  // illegal
        run_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0);  // jal
        run_instr(7'b0010011, 3'b110, 7'b0100000, 1'b0, 1'b0);  // ori ignores func7

        // Reset abort during MEMWRITE.
        bus.opcode = 7'b0100011; bus.func3 = 3'b010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("abort_pre_state", 32'(bus.State), 32'd5);
        check_val("abort_pre_memwrite", 32'(bus.MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_memwrite", 32'(bus.MemWrite), 32'd0);
        check_val("abort_state", 32'(bus.State), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MEM_WAIT_EN
        bus.opcode = 7'b0100011; bus.func3 = 3'b010;
        bus.mem_ready = 1'b0;
        #1;
        check_val("stall_fetch_irwrite", 32'(bus.IRWrite), 32'd0);
        check_val("stall_fetch_pcwrite", 32'(bus.PCWrite), 32'd0);
        @(posedge clk); @(negedge clk);
        check_val("stall_fetch_state", 32'(bus.State), 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        check_val("stall_fetch_go", 32'(bus.IRWrite), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_val("stall_sw_state", 32'(bus.State), 32'd5);
            check_val("stall_sw_memwrite", 32'(bus.MemWrite), 32'd1);
            @(posedge clk); @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        check_val("stall_sw_memwrite_last", 32'(bus.MemWrite), 32'd1);
        @(posedge clk); @(negedge clk);
        check_val("stall_sw_done", 32'(bus.State), 32'd0);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 7)];
            if (op == 7'b0000000) begin
                op = 7'($urandom);
            end else begin
                op = op;
            end
            run_instr(op, 3'($urandom), 7'($urandom),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
